// File: rtl/cordic_controller.sv
// CORDIC sequencer: decodes host commands from the control register, drives
// the micro-rotation datapath for N iterations, waits out datapath latency,
// captures the results and writes status back into the control register.
module cordic_controller #(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_ITER   = 24,
   parameter int ITER_BITS  = 5,
   parameter int DP_LATENCY = 1
) (
   input  logic                  S_AXI_ACLK,
   input  logic                  S_AXI_ARESETN,
   input  logic [DATA_WIDTH-1:0] ctrl_in,
   output logic [DATA_WIDTH-1:0] ctrl_out,
   output logic                  ctrl_we,
   input  logic [DATA_WIDTH-1:0] x_in,
   input  logic [DATA_WIDTH-1:0] y_in,
   input  logic [DATA_WIDTH-1:0] z_in,
   output logic [DATA_WIDTH-1:0] x_result,
   output logic [DATA_WIDTH-1:0] y_result,
   output logic [DATA_WIDTH-1:0] z_result,
   output logic                  dp_load,
   output logic [DATA_WIDTH-1:0] dp_x0,
   output logic [DATA_WIDTH-1:0] dp_y0,
   output logic [DATA_WIDTH-1:0] dp_z0,
   output logic                  dp_en,
   output logic [ITER_BITS-1:0]  dp_iter,
   output logic                  dp_mode,
   input  logic [DATA_WIDTH-1:0] dp_x,
   input  logic [DATA_WIDTH-1:0] dp_y,
   input  logic [DATA_WIDTH-1:0] dp_z,
   input  logic                  dp_ovf,
   output logic                  irq
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_ITER  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_WB    = 3'd4;

   localparam int B_START   = 0;
   localparam int B_MODE    = 1;
   localparam int B_INT_EN  = 2;
   localparam int B_CLEAR   = 3;
   localparam int B_COUNT   = 8;
   localparam int B_BUSY    = 24;
   localparam int B_DONE    = 25;
   localparam int B_OVF     = 26;
   localparam int B_CFG_ERR = 27;

   // DRAIN holds DP_LATENCY-1 cycles; the counter is sized for the worst case
   localparam int DB = $clog2(DP_LATENCY + 1);
   localparam logic [DB-1:0] DRAIN_LAST = DB'((DP_LATENCY > 1) ? (DP_LATENCY - 2) : 0);
   localparam logic [2:0] AFTER_ITER = (DP_LATENCY == 1) ? S_WB : S_DRAIN;

   logic [2:0]            state;
   logic [ITER_BITS-1:0]  iter_idx;
   logic [ITER_BITS-1:0]  count_q;
   logic                  mode_q;
   logic                  ovf_q;
   logic [DB-1:0]         drain_cnt;
   logic [DP_LATENCY-1:0] en_pipe;

   logic [ITER_BITS-1:0]  cfg_count;
   logic                  cfg_legal;
   logic                  result_valid;
   logic                  ovf_now;

   assign cfg_count    = ctrl_in[B_COUNT +: ITER_BITS];
   assign cfg_legal    = (cfg_count != '0) && (cfg_count <= ITER_BITS'(MAX_ITER));
   assign result_valid = en_pipe[DP_LATENCY-1];
   assign ovf_now      = result_valid & dp_ovf;
   assign dp_mode      = mode_q;
   assign irq          = S_AXI_ARESETN & ctrl_in[B_DONE] & ctrl_in[B_INT_EN];

   // Delay line of dp_en marking the cycles in which a datapath result is valid
   generate
      if (DP_LATENCY == 1) begin : g_pipe_one
         always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN) en_pipe <= '0;
            else                en_pipe <= dp_en;
         end
      end else begin : g_pipe_multi
         always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN) en_pipe <= '0;
            else                en_pipe <= {en_pipe[DP_LATENCY-2:0], dp_en};
         end
      end
   endgenerate

   // Output decode: datapath strobes and control register write-back per state
   always_comb begin
      ctrl_we  = 1'b0;
      ctrl_out = '0;
      dp_load  = 1'b0;
      dp_x0    = '0;
      dp_y0    = '0;
      dp_z0    = '0;
      dp_en    = 1'b0;
      dp_iter  = '0;
      case (state)
         S_IDLE: begin
            if (ctrl_in[B_START]) begin
               ctrl_we              = 1'b1;
               ctrl_out             = ctrl_in;
               ctrl_out[B_START]    = 1'b0;
               ctrl_out[B_CLEAR]    = 1'b0;
               ctrl_out[B_OVF]      = 1'b0;
               ctrl_out[B_BUSY]     = cfg_legal;
               ctrl_out[B_DONE]     = ~cfg_legal;
               ctrl_out[B_CFG_ERR]  = ~cfg_legal;
            end else if (ctrl_in[B_CLEAR]) begin
               ctrl_we              = 1'b1;
               ctrl_out             = ctrl_in;
               ctrl_out[B_CLEAR]    = 1'b0;
               ctrl_out[B_DONE]     = 1'b0;
               ctrl_out[B_OVF]      = 1'b0;
               ctrl_out[B_CFG_ERR]  = 1'b0;
            end
         end
         S_LOAD: begin
            dp_load = 1'b1;
            dp_x0   = x_in;
            dp_y0   = y_in;
            dp_z0   = z_in;
         end
         S_ITER: begin
            dp_en   = 1'b1;
            dp_iter = iter_idx;
         end
         S_WB: begin
            ctrl_we              = 1'b1;
            ctrl_out             = ctrl_in;
            ctrl_out[B_START]    = 1'b0;
            ctrl_out[B_BUSY]     = 1'b0;
            ctrl_out[B_DONE]     = 1'b1;
            ctrl_out[B_OVF]      = ovf_q | ovf_now;
            ctrl_out[B_CFG_ERR]  = 1'b0;
         end
         default: ;
      endcase
   end

   // Sequencer state, latched command, iteration/drain counters, sticky overflow and results
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state     <= S_IDLE;
         iter_idx  <= '0;
         count_q   <= '0;
         mode_q    <= 1'b0;
         ovf_q     <= 1'b0;
         drain_cnt <= '0;
         x_result  <= '0;
         y_result  <= '0;
         z_result  <= '0;
      end else begin
         if (state != S_IDLE && ovf_now) ovf_q <= 1'b1;
         case (state)
            S_IDLE: begin
               if (ctrl_in[B_START] && cfg_legal) begin
                  state    <= S_LOAD;
                  mode_q   <= ctrl_in[B_MODE];
                  count_q  <= cfg_count;
                  iter_idx <= '0;
                  ovf_q    <= 1'b0;
               end
            end
            S_LOAD: state <= S_ITER;
            S_ITER: begin
               if (iter_idx == count_q - ITER_BITS'(1)) begin
                  iter_idx  <= '0;
                  drain_cnt <= '0;
                  state     <= AFTER_ITER;
               end else begin
                  iter_idx <= iter_idx + ITER_BITS'(1);
               end
            end
            S_DRAIN: begin
               if (drain_cnt == DRAIN_LAST) state <= S_WB;
               else                         drain_cnt <= drain_cnt + DB'(1);
            end
            S_WB: begin
               x_result <= dp_x;
               y_result <= dp_y;
               z_result <= dp_z;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_controller.sv
// Directed bench for cordic_controller: one instance with DP_LATENCY=1 and one
// with DP_LATENCY=3, each wired to a small control-register model in which the
// controller write-back takes priority over host writes.
module tb_cordic_controller;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   localparam logic [31:0] XI = 32'h0000_0011, YI = 32'h0000_0022, ZI = 32'h0000_0033;
   localparam logic [31:0] DX = 32'h0000_1234, DY = 32'h0000_5678, DZ = 32'h0000_9ABC;

   logic [31:0] x_in = XI, y_in = YI, z_in = ZI;
   logic [31:0] dp_x = DX, dp_y = DY, dp_z = DZ;

   // instance with DP_LATENCY = 1
   logic [31:0] reg1, out1, hd1, xr1, yr1, zr1, x01, y01, z01;
   logic        we1, hw1, load1, en1, mode1, ovf1, irq1;
   logic [4:0]  iter1;
   // instance with DP_LATENCY = 3
   logic [31:0] reg3, out3, hd3, xr3, yr3, zr3, x03, y03, z03;
   logic        we3, hw3, load3, en3, mode3, ovf3, irq3;
   logic [4:0]  iter3;

   int checks = 0;
   int fails  = 0;

   cordic_controller #(.DATA_WIDTH(32), .MAX_ITER(24), .ITER_BITS(5), .DP_LATENCY(1)) d1 (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .ctrl_in(reg1), .ctrl_out(out1), .ctrl_we(we1),
      .x_in(x_in), .y_in(y_in), .z_in(z_in), .x_result(xr1), .y_result(yr1), .z_result(zr1),
      .dp_load(load1), .dp_x0(x01), .dp_y0(y01), .dp_z0(z01), .dp_en(en1), .dp_iter(iter1),
      .dp_mode(mode1), .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z), .dp_ovf(ovf1), .irq(irq1));

   cordic_controller #(.DATA_WIDTH(32), .MAX_ITER(24), .ITER_BITS(5), .DP_LATENCY(3)) d3 (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .ctrl_in(reg3), .ctrl_out(out3), .ctrl_we(we3),
      .x_in(x_in), .y_in(y_in), .z_in(z_in), .x_result(xr3), .y_result(yr3), .z_result(zr3),
      .dp_load(load3), .dp_x0(x03), .dp_y0(y03), .dp_z0(z03), .dp_en(en3), .dp_iter(iter3),
      .dp_mode(mode3), .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z), .dp_ovf(ovf3), .irq(irq3));

   // control register models: controller write-back wins over a host write
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)   reg1 <= '0;
      else if (we1) reg1 <= out1;
      else if (hw1) reg1 <= hd1;
   end
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)   reg3 <= '0;
      else if (we3) reg3 <= out3;
      else if (hw3) reg3 <= hd3;
   end

   // host writes: called at a negedge, return at the next negedge (cycle 0 of the command)
   task automatic host_write1(input logic [31:0] v);
      hw1 = 1'b1; hd1 = v;
      @(negedge clk);
      hw1 = 1'b0;
   endtask
   task automatic host_write3(input logic [31:0] v);
      hw3 = 1'b1; hd3 = v;
      @(negedge clk);
      hw3 = 1'b0;
   endtask

   // full operation on the latency-1 instance; result ovf_res carries dp_ovf (-1 = none)
   task automatic run1(input string name, input logic [31:0] cmd, input int n, input logic mode_exp,
                       input int ovf_res, input logic [31:0] exp_first, input logic [31:0] exp_wb);
      host_write1(cmd);
      checks++; if ({we1, out1} !== {1'b1, exp_first}) begin fails++;
         $display("[TB] FAIL %s start_wb: got we=%b out=%h expected we=1 out=%h", name, we1, out1, exp_first); end
      for (int c = 1; c <= n + 2; c++) begin
         @(negedge clk);
         ovf1 = (ovf_res >= 0) && (c == ovf_res + 3);
         #1;
         if (c == 1) begin
            checks++; if ({load1, en1, we1, mode1, x01, y01, z01} !== {1'b1, 1'b0, 1'b0, mode_exp, XI, YI, ZI}) begin fails++;
               $display("[TB] FAIL %s load: got load=%b en=%b mode=%b x0=%h expected load=1 en=0 mode=%b x0=%h", name, load1, en1, mode1, x01, mode_exp, XI); end
         end else if (c <= n + 1) begin
            checks++; if ({en1, load1, we1, iter1} !== {1'b1, 1'b0, 1'b0, 5'(c - 2)}) begin fails++;
               $display("[TB] FAIL %s iter cycle %0d: got en=%b we=%b iter=%0d expected en=1 we=0 iter=%0d", name, c, en1, we1, iter1, c - 2); end
         end else begin
            checks++; if ({we1, en1, out1} !== {1'b1, 1'b0, exp_wb}) begin fails++;
               $display("[TB] FAIL %s writeback: got we=%b en=%b out=%h expected we=1 en=0 out=%h", name, we1, en1, out1, exp_wb); end
         end
      end
      @(negedge clk);
      ovf1 = 1'b0;
      checks++; if ({xr1, yr1, zr1, reg1, we1} !== {DX, DY, DZ, exp_wb, 1'b0}) begin fails++;
         $display("[TB] FAIL %s results: got x=%h y=%h z=%h reg=%h we=%b expected x=%h y=%h z=%h reg=%h we=0", name, xr1, yr1, zr1, reg1, we1, DX, DY, DZ, exp_wb); end
   endtask

   // full operation on the latency-3 instance; dp_ovf high in cycles lo..hi
   task automatic run3(input string name, input logic [31:0] cmd, input int lo, input int hi, input logic [31:0] exp_wb);
      host_write3(cmd);
      checks++; if ({we3, out3} !== {1'b1, 32'h0100_0400}) begin fails++;
         $display("[TB] FAIL %s start_wb: got we=%b out=%h expected we=1 out=01000400", name, we3, out3); end
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         ovf3 = (c >= lo) && (c <= hi);
         #1;
         if (c == 1) begin
            checks++; if ({load3, en3, we3} !== 3'b100) begin fails++;
               $display("[TB] FAIL %s load: got load=%b en=%b we=%b expected 1 0 0", name, load3, en3, we3); end
         end else if (c <= 5) begin
            checks++; if ({en3, we3, iter3} !== {1'b1, 1'b0, 5'(c - 2)}) begin fails++;
               $display("[TB] FAIL %s iter cycle %0d: got en=%b we=%b iter=%0d expected en=1 we=0 iter=%0d", name, c, en3, we3, iter3, c - 2); end
         end else if (c <= 7) begin
            checks++; if ({en3, we3, load3} !== 3'b000) begin fails++;
               $display("[TB] FAIL %s drain cycle %0d: got en=%b we=%b load=%b expected 0 0 0", name, c, en3, we3, load3); end
         end else begin
            checks++; if ({we3, out3} !== {1'b1, exp_wb}) begin fails++;
               $display("[TB] FAIL %s writeback: got we=%b out=%h expected we=1 out=%h", name, we3, out3, exp_wb); end
         end
      end
      @(negedge clk);
      ovf3 = 1'b0;
      checks++; if ({xr3, reg3, we3} !== {DX, exp_wb, 1'b0}) begin fails++;
         $display("[TB] FAIL %s results: got x=%h reg=%h we=%b expected x=%h reg=%h we=0", name, xr3, reg3, we3, DX, exp_wb); end
   endtask

   task automatic test_reset();
      int seen_we, seen_en;
      #1;
      checks++; if ({we1, out1, load1, en1, iter1, irq1, xr1, x01} !== '0) begin fails++;
         $display("[TB] FAIL reset_initial: got we=%b out=%h load=%b en=%b iter=%0d irq=%b x=%h expected all 0", we1, out1, load1, en1, iter1, irq1, xr1); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      host_write1(32'h0000_1001);
      repeat (7) @(negedge clk);
      checks++; if ({en1, iter1} !== {1'b1, 5'd5}) begin fails++;
         $display("[TB] FAIL reset_preiter: got en=%b iter=%0d expected en=1 iter=5", en1, iter1); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({we1, out1, load1, en1, iter1, irq1, x01, mode1} !== '0) begin fails++;
         $display("[TB] FAIL reset_midrun: got we=%b out=%h load=%b en=%b iter=%0d irq=%b expected all 0", we1, out1, load1, en1, iter1, irq1); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen_we = 0; seen_en = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (we1) seen_we++;
         if (en1 || load1) seen_en++;
      end
      checks++; if (seen_we != 0 || seen_en != 0) begin fails++;
         $display("[TB] FAIL reset_after: got we_cycles=%0d dp_cycles=%0d expected 0 0", seen_we, seen_en); end
   endtask

   task automatic test_rotation();
      run1("rotation", 32'h0000_1001, 16, 1'b0, -1, 32'h0100_1000, 32'h0200_1000);
      checks++; if (irq1 !== 1'b0) begin fails++;
         $display("[TB] FAIL rotation_irq: got %b expected 0", irq1); end
   endtask

   task automatic test_illegal();
      host_write1(32'h0000_0001);
      checks++; if ({we1, out1} !== {1'b1, 32'h0A00_0000}) begin fails++;
         $display("[TB] FAIL illegal_zero: got we=%b out=%h expected we=1 out=0a000000", we1, out1); end
      @(negedge clk);
      checks++; if ({load1, we1, reg1} !== {1'b0, 1'b0, 32'h0A00_0000}) begin fails++;
         $display("[TB] FAIL illegal_zero_after: got load=%b we=%b reg=%h expected 0 0 0a000000", load1, we1, reg1); end
      host_write1(32'h0000_1901);
      checks++; if ({we1, out1} !== {1'b1, 32'h0A00_1900}) begin fails++;
         $display("[TB] FAIL illegal_25: got we=%b out=%h expected we=1 out=0a001900", we1, out1); end
      @(negedge clk);
      checks++; if ({load1, we1, en1} !== 3'b000) begin fails++;
         $display("[TB] FAIL illegal_25_after: got load=%b we=%b en=%b expected 0 0 0", load1, we1, en1); end
      host_write1(32'h0000_0008);
      checks++; if ({we1, out1} !== {1'b1, 32'h0000_0000}) begin fails++;
         $display("[TB] FAIL illegal_clear: got we=%b out=%h expected we=1 out=00000000", we1, out1); end
      @(negedge clk);
   endtask

   task automatic test_overflow_irq();
      run1("overflow", 32'h0000_0807, 8, 1'b1, 3, 32'h0100_0806, 32'h0600_0806);
      checks++; if (irq1 !== 1'b1) begin fails++;
         $display("[TB] FAIL overflow_irq_set: got %b expected 1", irq1); end
      host_write1(32'h0600_080E);
      checks++; if ({we1, out1} !== {1'b1, 32'h0000_0806}) begin fails++;
         $display("[TB] FAIL overflow_clear: got we=%b out=%h expected we=1 out=00000806", we1, out1); end
      @(negedge clk);
      checks++; if ({irq1, reg1} !== {1'b0, 32'h0000_0806}) begin fails++;
         $display("[TB] FAIL overflow_irq_clear: got irq=%b reg=%h expected irq=0 reg=00000806", irq1, reg1); end
   endtask

   task automatic test_back_to_back();
      int extra;
      host_write1(32'h0000_0801);
      checks++; if ({we1, out1} !== {1'b1, 32'h0100_0800}) begin fails++;
         $display("[TB] FAIL busy_start: got we=%b out=%h expected we=1 out=01000800", we1, out1); end
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         hw1 = (c == 5); hd1 = 32'h0100_0401;
         #1;
         if (c >= 2 && c <= 9) begin
            checks++; if ({en1, we1, iter1} !== {1'b1, 1'b0, 5'(c - 2)}) begin fails++;
               $display("[TB] FAIL busy_iter cycle %0d: got en=%b we=%b iter=%0d expected en=1 we=0 iter=%0d", c, en1, we1, iter1, c - 2); end
         end else if (c == 10) begin
            checks++; if ({we1, en1, out1} !== {1'b1, 1'b0, 32'h0200_0400}) begin fails++;
               $display("[TB] FAIL busy_writeback: got we=%b en=%b out=%h expected we=1 en=0 out=02000400", we1, en1, out1); end
         end
      end
      hw1 = 1'b0;
      extra = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (load1 || en1 || we1) extra++;
      end
      checks++; if ({extra, reg1} !== {32'd0, 32'h0200_0400}) begin fails++;
         $display("[TB] FAIL busy_no_rerun: got active_cycles=%0d reg=%h expected 0 02000400", extra, reg1); end
   endtask

   task automatic test_latency3();
      run3("lat3_noovf", 32'h0000_0401, 1, 4, 32'h0200_0400);
      run3("lat3_lastovf", 32'h0000_0401, 8, 8, 32'h0600_0400);
   endtask

   initial begin
      hw1 = 1'b0; hd1 = '0; ovf1 = 1'b0;
      hw3 = 1'b0; hd3 = '0; ovf3 = 1'b0;
      test_reset();
      test_rotation();
      test_illegal();
      test_overflow_irq();
      test_back_to_back();
      test_latency3();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
